camera_frame_capture: RTL and testbench

Converts the OV7670 parallel byte stream into RGB444 pixels and write addresses for the 320x240 frame buffer BRAM port A. It runs entirely in the camera `pclk` domain, between the camera pins and the frame buffer. It frames capture on VSYNC and HREF, and places pixels by line and column so that short or long lines cannot skew the image. Optional 2:1 decimation accepts a VGA-mode camera into the QVGA buffer.

---
 rtl/camera_frame_capture.sv | 175 +++++++++++++++++
 tb/tb_camera_frame_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_capture.sv
// OV7670 byte stream to RGB444 pixel writes for a line/column addressed frame buffer.
// Framed by VSYNC/HREF in the pclk domain, with optional 2:1 decimation in both axes.
module camera_frame_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int DECIMATE = 0
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [7:0]  D,
    input  logic        vsync,
    input  logic        href,
    output logic [11:0] RGB,
    output logic [16:0] wr_addr,
    output logic        wr_en,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        line_err
);

    localparam logic [8:0]  COL_MAX   = 9'(H_ACTIVE);
    localparam logic [7:0]  LINE_MAX  = 8'(V_ACTIVE);
    localparam logic [7:0]  LINE_LAST = 8'(V_ACTIVE - 1);
    localparam logic [9:0]  CAND_FULL = 10'(H_ACTIVE);
    localparam logic [16:0] LINE_STEP = 17'(H_ACTIVE);

    typedef enum logic [1:0] {SYNC, ARM, CAPTURE} state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  r_q, r_d;
    logic        href_q, href_d;
    logic [8:0]  column_q, column_d;
    logic [7:0]  line_q, line_d;
    logic [16:0] line_base_q, line_base_d;
    logic        src_pix_odd_q, src_pix_odd_d;
    logic [8:0]  src_line_q, src_line_d;
    logic [9:0]  cand_q, cand_d;
    logic [11:0] rgb_q, rgb_d;
    logic [16:0] wr_addr_q, wr_addr_d;
    logic        wr_en_q, wr_en_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        line_err_q, line_err_d;

    logic line_kept;
    logic pix_kept;

    always_comb begin
        line_kept = (line_q < LINE_MAX) && ((DECIMATE == 0) || !src_line_q[0]);
        pix_kept  = (DECIMATE == 0) || !src_pix_odd_q;
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        r_d           = r_q;
        href_d        = 1'b0;
        column_d      = column_q;
        line_d        = line_q;
        line_base_d   = line_base_q;
        src_pix_odd_d = src_pix_odd_q;
        src_line_d    = src_line_q;
        cand_d        = cand_q;
        rgb_d         = rgb_q;
        wr_addr_d     = wr_addr_q;
        wr_en_d       = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        line_err_d    = 1'b0;

        case (state_q)
            SYNC: begin
                if (vsync) state_d = ARM;
            end
            ARM: begin
                phase_d       = 1'b0;
                column_d      = '0;
                line_d        = '0;
                line_base_d   = '0;
                src_pix_odd_d = 1'b0;
                src_line_d    = '0;
                cand_d        = '0;
                if (!vsync) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (vsync) begin
                    // vsync wins over any href edge on the same cycle; ARM drops the pending byte
                    state_d       = ARM;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    href_d = href;
                    if (href) begin
                        if (!phase_q) begin
                            r_d     = D[3:0];
                            phase_d = 1'b1;
                        end else begin
                            phase_d       = 1'b0;
                            src_pix_odd_d = !src_pix_odd_q;
                            if (line_kept && pix_kept) begin
                                if (cand_q != '1) cand_d = cand_q + 10'd1;
                                if (column_q < COL_MAX) begin
                                    wr_en_d   = 1'b1;
                                    rgb_d     = {r_q, D};
                                    wr_addr_d = line_base_q + 17'(column_q);
                                    column_d  = column_q + 9'd1;
                                end
                            end
                        end
                    end else if (href_q) begin
                        // cand counts filter-passing pixels even past the last column, so long lines flag too
                        phase_d       = 1'b0;
                        src_pix_odd_d = 1'b0;
                        cand_d        = '0;
                        line_err_d    = phase_q || (line_kept && (cand_q != CAND_FULL));
                        if (src_line_q != '1) src_line_d = src_line_q + 9'd1;
                        if (line_kept) begin
                            line_d   = line_q + 8'd1;
                            column_d = '0;
                            if (line_q < LINE_LAST) line_base_d = line_base_q + LINE_STEP;
                        end
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q       <= SYNC;
            phase_q       <= 1'b0;
            r_q           <= '0;
            href_q        <= 1'b0;
            column_q      <= '0;
            line_q        <= '0;
            line_base_q   <= '0;
            src_pix_odd_q <= 1'b0;
            src_line_q    <= '0;
            cand_q        <= '0;
            rgb_q         <= '0;
            wr_addr_q     <= '0;
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            r_q           <= r_d;
            href_q        <= href_d;
            column_q      <= column_d;
            line_q        <= line_d;
            line_base_q   <= line_base_d;
            src_pix_odd_q <= src_pix_odd_d;
            src_line_q    <= src_line_d;
            cand_q        <= cand_d;
            rgb_q         <= rgb_d;
            wr_addr_q     <= wr_addr_d;
            wr_en_q       <= wr_en_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            line_err_q    <= line_err_d;
        end
    end

    assign RGB         = rgb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_en       = wr_en_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign line_err    = line_err_q;

endmodule

// File: tb/tb_camera_frame_capture.sv
// Scoreboard bench for camera_frame_capture: a full-rate and a decimating instance share one
// scaled-down camera stream; expected writes are queued by stimulus and popped by a monitor.
module tb_camera_frame_capture;

    localparam int H = 8;
    localparam int V = 4;

    typedef struct packed {
        logic [16:0] a;
        logic [11:0] d;
    } wr_t;

    logic        clk;
    logic        reset;
    logic [7:0]  d_in;
    logic        vsync;
    logic        href;

    logic [11:0] rgb0, rgb1;
    logic [16:0] wr_addr0, wr_addr1;
    logic        wr_en0, wr_en1;
    logic        frame_done0, frame_done1;
    logic [7:0]  frame_count0, frame_count1;
    logic        line_err0, line_err1;

    camera_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(0)) u0 (
        .pclk(clk), .reset(reset), .D(d_in), .vsync(vsync), .href(href),
        .RGB(rgb0), .wr_addr(wr_addr0), .wr_en(wr_en0), .frame_done(frame_done0),
        .frame_count(frame_count0), .line_err(line_err0)
    );

    camera_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(1)) u1 (
        .pclk(clk), .reset(reset), .D(d_in), .vsync(vsync), .href(href),
        .RGB(rgb1), .wr_addr(wr_addr1), .wr_en(wr_en1), .frame_done(frame_done1),
        .frame_count(frame_count1), .line_err(line_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t q0[$];
    wr_t q1[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  fd0 = 0, fd1 = 0, le0 = 0, le1 = 0;
    int  exp_fd = 0, exp_le0 = 0, exp_le1 = 0;
    int  exp_fc = 0;
    bit  capturing = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops one expected write per observed strobe, counts pulses.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (wr_en0) begin
            chk("wr_spacing0", 32'(prev0), 32'd0);
            chk("addr_range0", 32'(wr_addr0 < 17'(H * V)), 32'd1);
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_wr0: got addr 0x%0h rgb 0x%0h expected no write at %0t",
                         wr_addr0, rgb0, $time);
            end else begin
                e = q0.pop_front();
                chk("wr_addr0", 32'(wr_addr0), 32'(e.a));
                chk("rgb0", 32'(rgb0), 32'(e.d));
            end
        end
        if (wr_en1) begin
            chk("wr_spacing1", 32'(prev1), 32'd0);
            chk("addr_range1", 32'(wr_addr1 < 17'(H * V)), 32'd1);
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_wr1: got addr 0x%0h rgb 0x%0h expected no write at %0t",
                         wr_addr1, rgb1, $time);
            end else begin
                e = q1.pop_front();
                chk("wr_addr1", 32'(wr_addr1), 32'(e.a));
                chk("rgb1", 32'(rgb1), 32'(e.d));
            end
        end
        prev0 = wr_en0;
        prev1 = wr_en1;
        if (frame_done0) fd0++;
        if (frame_done1) fd1++;
        if (line_err0) le0++;
        if (line_err1) le1++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        href  = 1'b0;
        vsync = 1'b1;
        if (capturing) begin
            exp_fd++;
            exp_fc = (exp_fc + 1) % 256;
        end
        idle(3);
        vsync = 1'b0;
        capturing = 1;
        idle(3);
    endtask

    // Pixel value = (x + y + seed); first byte carries junk high nibble 5.
    task automatic send_line(input int y, input int nb, input int seed, input bit fall);
        logic [11:0] p;
        wr_t e;
        int x;
        for (int b = 0; b < nb; b++) begin
            x = b / 2;
            p = 12'(x + y + seed);
            @(negedge clk);
            href = 1'b1;
            d_in = (b % 2 == 0) ? {4'h5, p[11:8]} : p[7:0];
            if (capturing && (b % 2 == 1)) begin
                e.d = p;
                if (y < V && x < H) begin
                    e.a = 17'(y * H + x);
                    q0.push_back(e);
                end
                if (y % 2 == 0 && x % 2 == 0 && y / 2 < V && x / 2 < H) begin
                    e.a = 17'((y / 2) * H + x / 2);
                    q1.push_back(e);
                end
            end
        end
        if (fall) begin
            @(negedge clk);
            href = 1'b0;
            if (capturing) begin
                if ((nb % 2 == 1) || (y < V && nb / 2 != H)) exp_le0++;
                if ((nb % 2 == 1) || (y % 2 == 0 && y / 2 < V && (nb / 2 + 1) / 2 != H)) exp_le1++;
            end
            idle(3);
        end
    endtask

    task automatic frame(input int lines, input int nb, input int seed);
        for (int y = 0; y < lines; y++) send_line(y, nb, seed, 1'b1);
    endtask

    task automatic checkpoint(input string tag);
        idle(4);
        chk({tag, "_q0_empty"}, 32'(q0.size()), 32'd0);
        chk({tag, "_q1_empty"}, 32'(q1.size()), 32'd0);
        chk({tag, "_frame_done0"}, 32'(fd0), 32'(exp_fd));
        chk({tag, "_frame_done1"}, 32'(fd1), 32'(exp_fd));
        chk({tag, "_frame_count0"}, 32'(frame_count0), 32'(exp_fc));
        chk({tag, "_frame_count1"}, 32'(frame_count1), 32'(exp_fc));
        chk({tag, "_line_err0"}, 32'(le0), 32'(exp_le0));
        chk({tag, "_line_err1"}, 32'(le1), 32'(exp_le1));
        q0.delete();
        q1.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wr_en0"}, 32'(wr_en0), 32'd0);
        chk({tag, "_rgb0"}, 32'(rgb0), 32'd0);
        chk({tag, "_wr_addr0"}, 32'(wr_addr0), 32'd0);
        chk({tag, "_frame_done0"}, 32'(frame_done0), 32'd0);
        chk({tag, "_frame_count0"}, 32'(frame_count0), 32'd0);
        chk({tag, "_line_err0"}, 32'(line_err0), 32'd0);
        chk({tag, "_wr_en1"}, 32'(wr_en1), 32'd0);
        chk({tag, "_wr_addr1"}, 32'(wr_addr1), 32'd0);
        chk({tag, "_frame_count1"}, 32'(frame_count1), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        d_in  = 8'h00;
        vsync = 1'b0;
        href  = 1'b0;
        idle(2);
        check_outputs_zero("reset");
        reset = 1'b0;

        // lines before the first vsync are discarded
        send_line(0, 2 * 2 * H, 0, 1'b1);
        checkpoint("pre_sync");

        vsync_pulse();
        frame(V, 2 * H, 0);
        vsync_pulse();
        checkpoint("ideal");

        // first bytes 0x5A, 0xC3 -> RGB 0xAC3 at address 0
        frame(V, 2 * H, 12'hAC3);
        vsync_pulse();
        checkpoint("byte_order");

        // short line 1, odd-length line 2; line 2 still starts at 2*H
        send_line(0, 2 * H, 3, 1'b1);
        send_line(1, 2 * H - 6, 3, 1'b1);
        send_line(2, 2 * H - 1, 3, 1'b1);
        send_line(3, 2 * H, 3, 1'b1);
        vsync_pulse();
        checkpoint("short_line");

        // double-size stream: decimating instance fills exactly H x V
        frame(2 * V, 4 * H, 9);
        vsync_pulse();
        checkpoint("vga_stream");

        // oversized frame: extra lines and pixels dropped, stored lines flagged
        frame(V + 2, 2 * H + 4, 21);
        vsync_pulse();
        checkpoint("oversize");

        // async reset in mid-line after a phase-0 byte
        send_line(0, 2 * H, 5, 1'b1);
        send_line(1, 7, 5, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        href  = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        capturing = 0;
        exp_fc = 0;
        idle(2);
        reset = 1'b0;
        frame(2, 2 * H, 11);
        checkpoint("post_reset_quiet");
        vsync_pulse();
        frame(V, 2 * H, 13);
        vsync_pulse();
        checkpoint("post_reset_frame");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
